// File: rtl/fechadura_core.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fechadura_core: electronic door-lock controller (passwords, lockout,      |
// | auto-relock, door-open beeper, master setup).         Revision: 1.0       |
// +---------------------------------------------------------------------------+
module fechadura_core #(
  parameter int N_USERS        = 4,
  parameter int N_DIG          = 20,
  parameter int MAX_TRIES      = 5,
  parameter int DEB_MS         = 100,
  parameter int NP_MS          = 3000,
  parameter int LOCK_BASE_S    = 30,
  parameter int LOCK_MAX_SHIFT = 3,
  parameter logic [N_DIG*4-1:0] DEFAULT_MASTER = {N_DIG{4'h1}}
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tick_ms,
  input  logic                                 sensor_contato,
  input  logic                                 botao_interno,
  input  logic                                 botao_bloqueio,
  input  logic                                 botao_config,
  input  logic [N_DIG*4-1:0]                   digitos_value,
  input  logic                                 digitos_valid,
  input  logic [13+(N_USERS+1)*N_DIG*4-1:0]    setup_data,
  input  logic                                 setup_ok,
  output logic                                 tranca,
  output logic                                 bip,
  output logic                                 teclado_en,
  output logic                                 display_en,
  output logic                                 setup_on,
  output logic                                 bloqueado,
  output logic [$clog2(N_USERS+1)-1:0]         user_id
);

  localparam int P     = N_DIG * 4;
  localparam int CFG_W = 13 + (N_USERS + 1) * P;
  localparam int UID_W = $clog2(N_USERS + 1);
  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int LW    = $clog2(LOCK_MAX_SHIFT + 2);

  localparam logic [15:0]      c_np_last  = 16'(NP_MS - 1);
  localparam logic [15:0]      c_deb_last = 16'(DEB_MS - 1);
  localparam logic [CFG_W-1:0] c_cfg_rst  = {1'b1, 6'd5, 6'd5, DEFAULT_MASTER, {(N_USERS*P){1'b1}}};

  typedef enum logic [3:0] {
    S_AGUARDANDO   = 4'd0,
    S_FECHADA      = 4'd1,
    S_NAO_PERTURBE = 4'd2,
    S_ENCOSTADA    = 4'd3,
    S_ABERTA       = 4'd4,
    S_PORTA_BIP    = 4'd5,
    S_MASTER       = 4'd6,
    S_SETUP        = 4'd7,
    S_BLOQUEADO    = 4'd8
  } state_t;

  state_t           r_state;
  logic [CFG_W-1:0] r_cfg;
  logic [15:0]      r_hold;
  logic [17:0]      r_tmr;
  logic [TW-1:0]    r_tries;
  logic [LW-1:0]    r_lock;
  logic [UID_W-1:0] r_user;

  logic             w_bip_status;
  logic [5:0]       w_bip_time;
  logic [5:0]       w_aut_time;
  logic [P-1:0]     w_master;
  logic             w_match;
  logic [UID_W-1:0] w_slot;
  logic             w_d0_ign;
  logic             w_hold_btn;
  logic [15:0]      w_hold_last;
  logic             w_hold_done;
  logic [LW-1:0]    w_shift;
  logic [31:0]      w_tmr_lim;
  logic             w_tmr_done;

  assign w_bip_status = r_cfg[CFG_W-1];
  assign w_bip_time   = r_cfg[CFG_W-2 -: 6];
  assign w_aut_time   = r_cfg[CFG_W-8 -: 6];
  assign w_master     = r_cfg[N_USERS*P +: P];

  // Keypad control codes in digit 0 never count as a password attempt.
  assign w_d0_ign = (digitos_value[3:0] == 4'hE) || (digitos_value[3:0] == 4'hB) ||
                    (digitos_value[3:0] == 4'hF);

  // Lowest enabled slot wins; an all-0xF slot is disabled.
  always_comb begin
    w_match = 1'b0;
    w_slot  = '0;
    for (int i = 0; i < N_USERS; i++) begin
      if (!w_match && (r_cfg[i*P +: P] != {P{1'b1}}) && (r_cfg[i*P +: P] == digitos_value)) begin
        w_match = 1'b1;
        w_slot  = UID_W'(i);
      end
    end
  end

  always_comb begin
    w_hold_btn  = 1'b0;
    w_hold_last = c_deb_last;
    case (r_state)
      S_FECHADA: begin
        w_hold_btn  = botao_bloqueio | botao_interno;
        w_hold_last = botao_bloqueio ? c_np_last : c_deb_last;
      end
      S_NAO_PERTURBE, S_ENCOSTADA: w_hold_btn = botao_interno;
      S_ABERTA, S_PORTA_BIP:       w_hold_btn = botao_config;
      default:                     w_hold_btn = 1'b0;
    endcase
  end

  assign w_hold_done = tick_ms && w_hold_btn && (r_hold == w_hold_last);

  assign w_shift = r_lock - LW'(1);

  always_comb begin
    case (r_state)
      S_ENCOSTADA: w_tmr_lim = 32'(w_aut_time) * 32'd1000;
      S_ABERTA:    w_tmr_lim = 32'(w_bip_time) * 32'd1000;
      S_BLOQUEADO: w_tmr_lim = (32'(LOCK_BASE_S) << w_shift) * 32'd1000;
      default:     w_tmr_lim = 32'hFFFF_FFFF;
    endcase
  end

  assign w_tmr_done = tick_ms && (({14'd0, r_tmr} + 32'd1) >= w_tmr_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_AGUARDANDO;
      r_cfg   <= c_cfg_rst;
      r_hold  <= '0;
      r_tmr   <= '0;
      r_tries <= '0;
      r_lock  <= '0;
      r_user  <= '0;
    end else begin
      // Free-running counters; every state change below restarts both.
      if (tick_ms)
        r_tmr <= r_tmr + 18'd1;
      if (!w_hold_btn)
        r_hold <= '0;
      else if (tick_ms)
        r_hold <= r_hold + 16'd1;

      case (r_state)
        S_AGUARDANDO: begin
          if (!sensor_contato) begin
            r_state <= S_FECHADA; r_hold <= '0; r_tmr <= '0;
          end
        end
        S_FECHADA: begin
          if (w_hold_done) begin
            r_state <= botao_bloqueio ? S_NAO_PERTURBE : S_ENCOSTADA;
            r_hold  <= '0; r_tmr <= '0;
          end else if (digitos_valid && !w_d0_ign) begin
            if (w_match) begin
              r_state <= S_ENCOSTADA; r_hold <= '0; r_tmr <= '0;
              r_user  <= w_slot + UID_W'(1);
              r_tries <= '0;
              r_lock  <= '0;
            end else if (r_tries == TW'(MAX_TRIES - 1)) begin
              r_state <= S_BLOQUEADO; r_hold <= '0; r_tmr <= '0;
              r_tries <= '0;
              if (r_lock != LW'(LOCK_MAX_SHIFT + 1))
                r_lock <= r_lock + LW'(1);
            end else begin
              r_tries <= r_tries + TW'(1);
            end
          end
        end
        S_NAO_PERTURBE: begin
          if (w_hold_done) begin
            r_state <= S_ENCOSTADA; r_hold <= '0; r_tmr <= '0;
          end
        end
        S_ENCOSTADA: begin
          if (sensor_contato) begin
            r_state <= S_ABERTA; r_hold <= '0; r_tmr <= '0;
          end else if (w_hold_done || w_tmr_done) begin
            r_state <= S_FECHADA; r_hold <= '0; r_tmr <= '0;
          end
        end
        S_ABERTA: begin
          if (w_tmr_done) begin
            r_state <= S_PORTA_BIP; r_hold <= '0; r_tmr <= '0;
          end else if (!sensor_contato) begin
            r_state <= S_ENCOSTADA; r_hold <= '0; r_tmr <= '0;
          end else if (w_hold_done) begin
            r_state <= S_MASTER; r_hold <= '0; r_tmr <= '0;
          end
        end
        S_PORTA_BIP: begin
          if (!sensor_contato) begin
            r_state <= S_ENCOSTADA; r_hold <= '0; r_tmr <= '0;
          end else if (w_hold_done) begin
            r_state <= S_MASTER; r_hold <= '0; r_tmr <= '0;
          end
        end
        S_MASTER: begin
          if (digitos_valid) begin
            r_hold <= '0; r_tmr <= '0;
            if (digitos_value == w_master) begin
              r_state <= S_SETUP;
              r_user  <= '0;
            end else begin
              r_state <= S_ABERTA;
            end
          end
        end
        S_SETUP: begin
          if (setup_ok) begin
            r_state <= S_ABERTA; r_hold <= '0; r_tmr <= '0;
            r_cfg   <= setup_data;
          end
        end
        S_BLOQUEADO: begin
          if (w_tmr_done) begin
            r_state <= S_FECHADA; r_hold <= '0; r_tmr <= '0;
          end
        end
        default: begin
          r_state <= S_AGUARDANDO; r_hold <= '0; r_tmr <= '0;
        end
      endcase
    end
  end

  assign tranca     = (r_state == S_AGUARDANDO) || (r_state == S_FECHADA) ||
                      (r_state == S_NAO_PERTURBE) || (r_state == S_BLOQUEADO);
  assign bip        = (r_state == S_PORTA_BIP) && w_bip_status;
  assign teclado_en = (r_state == S_FECHADA) || (r_state == S_MASTER);
  assign setup_on   = (r_state == S_SETUP);
  assign display_en = teclado_en | setup_on;
  assign bloqueado  = (r_state == S_BLOQUEADO);
  assign user_id    = r_user;

endmodule
`default_nettype wire
